// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, fetches over a same-cycle req/ack port, honours stall and
// redirect, and splits LM/SM into one single-register micro-op per set bit.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_IR   = 16'hF000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pipe1_pc,
  output logic [15:0] pipe1_ir,
  output logic        pipe1_valid,
  output logic [2:0]  pipe1_mcount,
  output logic        pipe1_last
);

  typedef enum logic {
    FETCH  = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] ir_r;
  logic [7:0]  mask_r;
  logic [15:0] pipe1_pc_r;
  logic [15:0] pipe1_ir_r;
  logic        pipe1_valid_r;
  logic [2:0]  pipe1_mcount_r;
  logic        pipe1_last_r;

  logic [7:0]  src_mask_s;
  logic [15:0] src_ir_s;
  logic [7:0]  onehot_s;
  logic [7:0]  rem_mask_s;
  logic [15:0] uop_ir_s;
  logic        is_lmsm_s;

  // Isolate the lowest set bit of a register mask.
  function automatic logic [7:0] lowest_bit(input logic [7:0] m);
    return m & (~m + 8'd1);
  endfunction

  // Select the mask/IR feeding the micro-op generator: latched during
  // expansion, straight from memory when a new LM/SM is being accepted.
  always_comb begin
    src_mask_s = imem_rdata[7:0];
    src_ir_s   = imem_rdata;
    if (state_r == EXPAND) begin
      src_mask_s = mask_r;
      src_ir_s   = ir_r;
    end else begin
      src_mask_s = imem_rdata[7:0];
      src_ir_s   = imem_rdata;
    end
    onehot_s   = lowest_bit(src_mask_s);
    rem_mask_s = src_mask_s & ~onehot_s;
    uop_ir_s   = {src_ir_s[15:9], 1'b0, onehot_s};
    is_lmsm_s  = (imem_rdata[15:13] == 3'b011);
  end

  // Fetch is requested only in FETCH and never while reset is asserted.
  assign imem_req  = reset_n & (state_r == FETCH);
  assign imem_addr = pc_r;

  assign pipe1_pc     = pipe1_pc_r;
  assign pipe1_ir     = pipe1_ir_r;
  assign pipe1_valid  = pipe1_valid_r;
  assign pipe1_mcount = pipe1_mcount_r;
  assign pipe1_last   = pipe1_last_r;

  // PC, expansion state and IF/ID register update; redirect > stall > expand > fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= FETCH;
      pc_r           <= RESET_PC;
      ir_r           <= NOP_IR;
      mask_r         <= 8'h00;
      pipe1_pc_r     <= 16'h0000;
      pipe1_ir_r     <= NOP_IR;
      pipe1_valid_r  <= 1'b0;
      pipe1_mcount_r <= 3'd0;
      pipe1_last_r   <= 1'b1;
    end else if (redirect) begin
      state_r        <= FETCH;
      pc_r           <= redirect_pc;
      mask_r         <= 8'h00;
      pipe1_ir_r     <= NOP_IR;
      pipe1_valid_r  <= 1'b0;
      pipe1_mcount_r <= 3'd0;
      pipe1_last_r   <= 1'b1;
    end else if (stall) begin
      // Everything holds; an ack during stall is dropped and refetched later.
      state_r <= state_r;
    end else begin
      case (state_r)
        EXPAND: begin
          // pipe1_pc keeps the LM/SM address for every micro-op.
          pipe1_ir_r     <= uop_ir_s;
          pipe1_valid_r  <= 1'b1;
          pipe1_mcount_r <= pipe1_mcount_r + 3'd1;
          mask_r         <= rem_mask_s;
          if (rem_mask_s == 8'h00) begin
            pipe1_last_r <= 1'b1;
            pc_r         <= pc_r + 16'd1;
            state_r      <= FETCH;
          end else begin
            pipe1_last_r <= 1'b0;
          end
        end
        FETCH: begin
          if (imem_ack && is_lmsm_s) begin
            pipe1_pc_r     <= pc_r;
            pipe1_ir_r     <= uop_ir_s;
            pipe1_valid_r  <= 1'b1;
            pipe1_mcount_r <= 3'd0;
            ir_r           <= imem_rdata;
            mask_r         <= rem_mask_s;
            if (rem_mask_s == 8'h00) begin
              pipe1_last_r <= 1'b1;
              pc_r         <= pc_r + 16'd1;
            end else begin
              pipe1_last_r <= 1'b0;
              state_r      <= EXPAND;
            end
          end else if (imem_ack) begin
            pipe1_pc_r     <= pc_r;
            pipe1_ir_r     <= imem_rdata;
            pipe1_valid_r  <= 1'b1;
            pipe1_mcount_r <= 3'd0;
            pipe1_last_r   <= 1'b1;
            pc_r           <= pc_r + 16'd1;
          end else begin
            pipe1_ir_r     <= NOP_IR;
            pipe1_valid_r  <= 1'b0;
            pipe1_mcount_r <= 3'd0;
            pipe1_last_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan steps followed by random stimulus, all
// checked against a queue-based model of the fetch/expand behaviour.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pipe1_pc;
  logic [15:0] pipe1_ir;
  logic        pipe1_valid;
  logic [2:0]  pipe1_mcount;
  logic        pipe1_last;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] ir;
    logic [2:0]  mc;
    logic        last;
  } uop_t;

  uop_t        m_q[$];
  logic [15:0] m_pc;
  logic [15:0] e_pc;
  logic [15:0] e_ir;
  logic        e_valid;
  logic [2:0]  e_mc;
  logic        e_last;

  fetch_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pipe1_pc     (pipe1_pc),
    .pipe1_ir     (pipe1_ir),
    .pipe1_valid  (pipe1_valid),
    .pipe1_mcount (pipe1_mcount),
    .pipe1_last   (pipe1_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = 16'h0000;
    e_pc    = 16'h0000;
    e_ir    = NOP;
    e_valid = 1'b0;
    e_mc    = 3'd0;
    e_last  = 1'b1;
  endtask

  task automatic check_outputs();
    chk("pipe1_valid", {15'd0, pipe1_valid}, {15'd0, e_valid});
    chk("pipe1_ir", pipe1_ir, e_ir);
    if (e_valid) begin
      chk("pipe1_pc", pipe1_pc, e_pc);
      chk("pipe1_mcount", {13'd0, pipe1_mcount}, {13'd0, e_mc});
      chk("pipe1_last", {15'd0, pipe1_last}, {15'd0, e_last});
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", {15'd0, imem_req}, {15'd0, (m_q.size() == 0)});
  endtask

  // One clock: drive inputs, take the edge, update the model, compare.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                      input logic ack, input logic [15:0] data);
    uop_t op;
    int   n;
    stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ack; imem_rdata = data;
    @(posedge clk);
    #1;
    if (rd) begin
      m_pc = rpc; m_q.delete();
      e_valid = 1'b0; e_ir = NOP; e_mc = 3'd0; e_last = 1'b1;
    end else if (st) begin
      e_valid = e_valid;
    end else if (m_q.size() > 0 || ack) begin
      if (m_q.size() == 0) begin
        e_pc = m_pc;
        if (data[15:13] == 3'b011) begin
          n = 0;
          for (int i = 0; i < 8; i++) begin
            if (data[i]) begin
              op.ir = {data[15:9], 1'b0, 8'h00};
              op.ir[i] = 1'b1;
              op.mc = 3'(n);
              op.last = 1'b0;
              m_q.push_back(op);
              n++;
            end
          end
          if (n == 0) begin
            op.ir = {data[15:9], 1'b0, 8'h00}; op.mc = 3'd0; op.last = 1'b1;
            m_q.push_back(op);
          end else begin
            m_q[n-1].last = 1'b1;
          end
        end else begin
          op.ir = data; op.mc = 3'd0; op.last = 1'b1;
          m_q.push_back(op);
        end
      end
      op = m_q.pop_front();
      e_valid = 1'b1; e_ir = op.ir; e_mc = op.mc; e_last = op.last;
      if (m_q.size() == 0) m_pc = m_pc + 16'd1;
    end else begin
      e_valid = 1'b0; e_ir = NOP;
    end
    check_outputs();
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    model_reset();
    #12;
    chk("rst_pipe1_pc", pipe1_pc, 16'h0000);
    chk("rst_pipe1_ir", pipe1_ir, NOP);
    chk("rst_valid", {15'd0, pipe1_valid}, 16'd0);
    chk("rst_mcount", {13'd0, pipe1_mcount}, 16'd0);
    chk("rst_last", {15'd0, pipe1_last}, 16'd1);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    reset_n = 1'b1;
    #1;
    chk("req_after_rst", {15'd0, imem_req}, 16'd1);

    // Straight-line ADDs, then stall for two cycles after pipe1_pc=1.
    step(0, 0, 16'h0, 1, 16'h1001);
    chk("add0_pc", pipe1_pc, 16'h0000);
    step(0, 0, 16'h0, 1, 16'h1002);
    chk("add1_pc", pipe1_pc, 16'h0001);
    step(1, 0, 16'h0, 1, 16'h1003);
    step(1, 0, 16'h0, 1, 16'h1003);
    chk("stall_pc", pipe1_pc, 16'h0001);
    chk("stall_addr", imem_addr, 16'h0002);
    step(0, 0, 16'h0, 1, 16'h1003);
    chk("resume_pc", pipe1_pc, 16'h0002);

    // Stall and redirect on the same edge: redirect wins.
    step(1, 1, 16'h0040, 1, 16'h1004);
    chk("redir_addr", imem_addr, 16'h0040);

    // LM at PC 5 with mask 1010_0010, then LM with empty mask.
    step(0, 1, 16'h0005, 0, 16'h0000);
    step(0, 0, 16'h0, 1, 16'h60A2);
    chk("lm_uop0", pipe1_ir, 16'h6002);
    chk("lm_req0", {15'd0, imem_req}, 16'd0);
    step(0, 0, 16'h0, 1, 16'h1234);
    chk("lm_uop1", pipe1_ir, 16'h6020);
    step(0, 0, 16'h0, 1, 16'h1234);
    chk("lm_uop2", pipe1_ir, 16'h6080);
    chk("lm_pc", pipe1_pc, 16'h0005);
    chk("lm_next_addr", imem_addr, 16'h0006);
    step(0, 0, 16'h0, 1, 16'h6100);
    chk("lm0_ir", pipe1_ir, 16'h6000);
    chk("lm0_last", {15'd0, pipe1_last}, 16'd1);

    // Three ack-less cycles give three bubbles with the address held.
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 16'h1111);
    chk("bubble_addr", imem_addr, 16'h0007);

    // Redirect to the top of memory and wrap.
    step(0, 1, 16'hFFFF, 0, 16'h0000);
    step(0, 0, 16'h0, 1, 16'h2222);
    chk("wrap_pc", pipe1_pc, 16'hFFFF);
    chk("wrap_addr", imem_addr, 16'h0000);

    // Redirect in the middle of an SM expansion.
    step(0, 0, 16'h0, 1, 16'h70FF);
    step(0, 0, 16'h0, 1, 16'h0000);
    step(0, 1, 16'h0020, 1, 16'h0000);
    chk("abort_req", {15'd0, imem_req}, 16'd1);

    // Asynchronous reset in the middle of an expansion.
    step(0, 0, 16'h0, 1, 16'h70FF);
    step(0, 0, 16'h0, 1, 16'h0000);
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("mid_rst_req", {15'd0, imem_req}, 16'd0);
    chk("mid_rst_ir", pipe1_ir, NOP);
    chk("mid_rst_pc", pipe1_pc, 16'h0000);
    chk("mid_rst_last", {15'd0, pipe1_last}, 16'd1);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    #2;
    reset_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        st, rd, ack;
      logic [15:0] rpc, data;
      st  = ($urandom_range(0, 9) < 2);
      rd  = ($urandom_range(0, 19) == 0);
      ack = ($urandom_range(0, 9) < 8);
      rpc = 16'($urandom);
      data = 16'($urandom);
      if ($urandom_range(0, 2) == 0) data[15:13] = 3'b011;
      step(st, rd, rpc, ack, data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
